branch_predictor_table: RTL and testbench

Parametrised branch direction predictor: a table of `2**IDX_W` saturating counters of `CNT_W` bits, indexed by `req_pc`. When `GSHARE=1`, the index is `req_pc` XORed with a global history register. It sits between the fetch stage, which issues prediction requests, and the execute stage, which returns resolved outcomes. It also keeps a saturating misprediction counter for performance monitoring.

---
 rtl/branch_predictor_table.sv | 118 +++++++++++
 tb/tb_branch_predictor_table.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_table.sv
// Branch direction predictor: a table of saturating counters with optional gshare
// indexing, resolution-time training and a saturating misprediction counter.

module bpt_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] value
);
    localparam logic [CNT_W-1:0] MAX  = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] WEAK = MAX >> 1;

    always_ff @(posedge clk) begin
        if (rst)
            value <= WEAK;
        else if (inc && value != MAX)
            value <= value + ONE;
        else if (dec && value != '0)
            value <= value - ONE;
    end
endmodule

module branch_predictor_table #(
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 2,
    parameter int HIST_W = 4,
    parameter bit GSHARE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             upd_pred,
    output logic [15:0]      mispred_cnt
);
    localparam int DEPTH = 1 << IDX_W;

    typedef struct packed {
        logic             taken;
        logic [IDX_W-1:0] idx;
    } pred_t;

    logic [DEPTH-1:0][CNT_W-1:0] ctr;
    logic [HIST_W-1:0]           hist;
    logic [HIST_W-1:0]           hist_nxt;
    logic [IDX_W-1:0]            idx;
    pred_t                       pred_q;
    logic [15:0]                 mis_q;

    // History is zero-extended into the low index bits before the xor.
    generate
        if (GSHARE) begin : g_gshare
            assign idx = req_pc ^ IDX_W'(hist);
        end else begin : g_bimodal
            assign idx = req_pc;
        end

        if (HIST_W == 1) begin : g_h1
            assign hist_nxt = upd_taken;
        end else begin : g_hn
            assign hist_nxt = {hist[HIST_W-2:0], upd_taken};
        end

        for (genvar i = 0; i < DEPTH; i++) begin : g_ent
            logic hit;
            assign hit = upd_valid && (upd_idx == IDX_W'(i));
            bpt_counter #(.CNT_W(CNT_W)) u_ctr (
                .clk  (clk),
                .rst  (rst),
                .inc  (hit && upd_taken),
                .dec  (hit && !upd_taken),
                .value(ctr[i])
            );
        end
    endgenerate

    // Table read is combinational, so a same-cycle update is not visible here.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid <= 1'b0;
            pred_q     <= '0;
        end else begin
            pred_valid <= req_valid;
            if (req_valid) begin
                pred_q.idx   <= idx;
                pred_q.taken <= ctr[idx][CNT_W-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            hist <= '0;
        else if (upd_valid)
            hist <= hist_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst)
            mis_q <= '0;
        else if (upd_valid && (upd_taken != upd_pred) && (mis_q != 16'hFFFF))
            mis_q <= mis_q + 16'd1;
    end

    assign pred_taken  = pred_q.taken;
    assign pred_idx    = pred_q.idx;
    assign mispred_cnt = mis_q;
endmodule

// File: tb/tb_branch_predictor_table.sv
// Drives a bimodal and a gshare instance with identical stimulus and checks both
// against a cycle model through expected/observed queues.

module tb_branch_predictor_table;
    logic       clk = 1'b0;
    logic       rst, req_valid, upd_valid, upd_taken, upd_pred;
    logic [3:0] req_pc, upd_idx;
    logic       pv0, pt0, pv1, pt1;
    logic [3:0] pi0, pi1;
    logic [15:0] mc0, mc1;

    typedef struct packed {
        logic        v0;
        logic        t0;
        logic [3:0]  i0;
        logic        v1;
        logic        t1;
        logic [3:0]  i1;
        logic [15:0] m0;
        logic [15:0] m1;
    } snap_t;

    snap_t expq[$];
    snap_t obsq[$];
    int nvec = 0;
    int nerr = 0;

    // reference model state
    int         tbl[16];
    logic [3:0] hist;
    logic [15:0] mis;
    logic       lv, lt0, lt1;
    logic [3:0] li0, li1;

    always #5 clk = ~clk;

    branch_predictor_table #(.IDX_W(4), .CNT_W(2), .HIST_W(4), .GSHARE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
        .pred_valid(pv0), .pred_taken(pt0), .pred_idx(pi0),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_pred(upd_pred), .mispred_cnt(mc0));

    branch_predictor_table #(.IDX_W(4), .CNT_W(2), .HIST_W(4), .GSHARE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
        .pred_valid(pv1), .pred_taken(pt1), .pred_idx(pi1),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_pred(upd_pred), .mispred_cnt(mc1));

    task automatic cycle(input logic r, input logic rv, input logic [3:0] pc,
                         input logic uv, input logic [3:0] ui, input logic ut,
                         input logic up);
        @(negedge clk);
        rst = r; req_valid = rv; req_pc = pc;
        upd_valid = uv; upd_idx = ui; upd_taken = ut; upd_pred = up;
        if (r) begin
            for (int k = 0; k < 16; k++) tbl[k] = 1;
            hist = '0; mis = '0;
            lv = 0; lt0 = 0; lt1 = 0; li0 = '0; li1 = '0;
        end else begin
            lv = rv;
            if (rv) begin
                li0 = pc;
                li1 = pc ^ hist;
                lt0 = (tbl[li0] >= 2);
                lt1 = (tbl[li1] >= 2);
            end
            if (uv) begin
                if (ut && tbl[ui] < 3) tbl[ui] = tbl[ui] + 1;
                else if (!ut && tbl[ui] > 0) tbl[ui] = tbl[ui] - 1;
                hist = {hist[2:0], ut};
                if (ut != up && mis != 16'hFFFF) mis = mis + 16'd1;
            end
        end
        expq.push_back('{lv, lt0, li0, lv, lt1, li1, mis, mis});
        @(posedge clk);
        #1;
        obsq.push_back('{pv0, pt0, pi0, pv1, pt1, pi1, mc0, mc1});
    endtask

    task automatic idle();
        cycle(0, 0, 4'd0, 0, 4'd0, 0, 0);
    endtask

    task automatic req(input logic [3:0] pc);
        cycle(0, 1, pc, 0, 4'd0, 0, 0);
    endtask

    task automatic upd(input logic [3:0] ui, input logic ut, input logic up);
        cycle(0, 0, 4'd0, 1, ui, ut, up);
    endtask

    task automatic do_reset();
        cycle(1, 0, 4'd0, 0, 4'd0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        for (int p = 0; p < 16; p++) req(4'(p));
        idle();
        idle();
        while (expq.size() > 0) begin
            snap_t e, o;
            e = expq.pop_front(); o = obsq.pop_front(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL reset: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (3) upd(4'd5, 1, 0);
        req(4'd5);
        upd(4'd5, 1, 1);
        req(4'd5);
        upd(4'd5, 0, 1);
        req(4'd5);
        upd(4'd5, 0, 1);
        req(4'd5);
        repeat (3) upd(4'd5, 0, 0);
        req(4'd5);
        idle();
        while (expq.size() > 0) begin
            snap_t e, o;
            e = expq.pop_front(); o = obsq.pop_front(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL saturation: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_gshare();
        do_reset();
        upd(4'd0, 1, 1);
        upd(4'd0, 0, 0);
        upd(4'd0, 1, 1);
        req(4'b0011);
        idle();
        while (expq.size() > 0) begin
            snap_t e, o;
            e = expq.pop_front(); o = obsq.pop_front(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL gshare: got %h want %h", o, e);
            end
        end
        nvec++;
        if (pi1 !== 4'b0110) begin
            nerr++;
            $display("FAIL gshare_idx: got %h want %h", pi1, 4'b0110);
        end
    endtask

    task automatic test_collision();
        do_reset();
        cycle(0, 1, 4'd2, 1, 4'd2, 1, 0);
        req(4'd2);
        upd(4'd2, 1, 0);
        cycle(0, 1, 4'd2, 1, 4'd2, 0, 1);
        req(4'd2);
        idle();
        while (expq.size() > 0) begin
            snap_t e, o;
            e = expq.pop_front(); o = obsq.pop_front(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL collision: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_mispred();
        do_reset();
        upd(4'd1, 1, 1);
        upd(4'd1, 0, 1);
        upd(4'd1, 1, 0);
        upd(4'd1, 0, 0);
        upd(4'd1, 0, 1);
        // preload the counter near its ceiling between edges
        force dut0.mis_q = 16'hFFFD;
        force dut1.mis_q = 16'hFFFD;
        #1;
        release dut0.mis_q;
        release dut1.mis_q;
        mis = 16'hFFFD;
        repeat (4) upd(4'd3, 1, 0);
        upd(4'd3, 1, 1);
        idle();
        while (expq.size() > 0) begin
            snap_t e, o;
            e = expq.pop_front(); o = obsq.pop_front(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL mispred: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (3) upd(4'd7, 1, 0);
        req(4'd7);
        cycle(1, 1, 4'd7, 1, 4'd7, 1, 0);
        req(4'd7);
        idle();
        while (expq.size() > 0) begin
            snap_t e, o;
            e = expq.pop_front(); o = obsq.pop_front(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL reset_mid: got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 99) == 0), 1'($urandom), 4'($urandom),
                  1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end
        idle();
        while (expq.size() > 0) begin
            snap_t e, o;
            e = expq.pop_front(); o = obsq.pop_front(); nvec++;
            if (o !== e) begin
                nerr++;
                $display("FAIL back_to_back: got %h want %h", o, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_pc = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_pred = 1'b0;
        test_reset();
        test_saturation();
        test_gshare();
        test_collision();
        test_mispred();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
